tron_arena_engine: RTL and testbench
====================================

// Module: tron_arena_engine
// PURPOSE
//  Parametrised Tron game core. Drives a W x H framebuffer RAM for 2..NUM_PLAYERS riders:
//  clears the arena, draws an optional border, places riders, then steps them on a tick.
//  Per step it detects crashes against trails, walls and other heads, retires crashed
//  riders and reports winner/game-over. Sits between input decoders and the VGA framebuffer.
// PARAMETERS
//  NUM_PLAYERS     4       rider count, 2..(2**COLOR_W-2)
//  SCREEN_WIDTH    320     arena width, pixels
//  SCREEN_HEIGHT   240     arena height, pixels
//  ADDR_W          19      RAM address width, >= clog2(W*H)
//  COLOR_W         3       pixel width; 0=empty, i+1=rider i, all-ones=border
//  CLOCKS_BY_TICK  100000  clocks per prescaler tick
//  STEP_TICKS      12      ticks per movement step
// PORTS
//  clock              in   1         system clock
//  reset_n            in   1         asynchronous, active-low reset
//  start              in   1         1-cycle pulse: begin new game (honoured in IDLE/OVER only)
//  wrap_mode          in   1         latched at start: 1=wrap edges, no border; 0=bordered
//  active_mask        in   NUM_PLAYERS   latched at start: riders taking part
//  dir_in             in   2*NUM_PLAYERS per-rider requested dir {0 UP,1 RIGHT,2 DOWN,3 LEFT}
//  ram_address        out  ADDR_W    y*SCREEN_WIDTH + x
//  ram_write_enabled  out  1         write strobe, one pixel per cycle
//  ram_write_data     out  COLOR_W   pixel value
//  ram_read_data      in   COLOR_W   sync read, valid 1 cycle after address
//  busy               out  1         high from start accept until OVER
//  alive              out  NUM_PLAYERS  riders still in play
//  game_over          out  1         high in OVER
//  winner_valid       out  1         exactly one rider alive at game over
//  winner_id          out  clog2(NUM_PLAYERS)  index of that rider, else 0
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; all outputs 0; mid-operation writes abort at once.
//  - IDLE -start-> CLEAR: writes 0 to addresses 0..W*H-1, one per cycle, ascending.
//  - CLEAR -> BORDER if !wrap_mode: writes all-ones to rows 0,H-1 and cols 0,H-2 interior
//    rows at x=0,W-1 (2W+2(H-2) writes); skipped when wrap_mode.
//  - PLACE: rider i (active) at x=(i+1)*W/(NUM_PLAYERS+1), y=H/2; dir UP if i even else DOWN;
//    writes colour i+1, one cycle each, inactive riders skipped. alive<=active_mask.
//  - If popcount(alive)<2 after PLACE -> OVER directly.
//  - WAIT: counter from 0; after CLOCKS_BY_TICK*STEP_TICKS cycles in WAIT -> STEP.
//  - STEP (1 cycle): dir_in sampled per alive rider; request opposite current dir ignored.
//    next pos = pos+dir; wrap_mode wraps modulo W/H; bordered mode never leaves arena (walls).
//  - Per alive rider, ascending index: READ (present next addr) -> CHECK (sample data).
//    Crash if data!=0, or next pos equals another alive rider's next pos (both crash).
//  - WRITE: after all checks, each alive non-crashed rider writes colour i+1 at next pos and
//    commits pos; crashed riders clear alive bit, keep pos, draw nothing. Outcome is
//    order-independent (all checks precede writes).
//  - After WRITE: popcount(alive)>=2 -> WAIT; else OVER.
//  - OVER: game_over=1, busy=0; winner_valid=(popcount==1), winner_id=that index.
//    start -> CLEAR (game_over, winner_* cleared same edge). start while busy ignored.
//  - ram_write_enabled high only in CLEAR, BORDER, PLACE, WRITE; address/data 0 otherwise.
// TESTING  (W=16,H=8,N=2,COLOR_W=3,CLOCKS_BY_TICK=2,STEP_TICKS=2, mask=2'b11)
//  1 start, wrap=0 -> 128 writes of 0 (addr 0..127), 44 writes of 7, then addr 69=1, 74=2.
//  2 dir p0=UP, p1=DOWN held -> step3 p1 hits y=7 wall: alive=01, game_over, winner 0.
//  3 wrap=1, p1 DOWN held -> y 5,6,7,0: step4 writes addr 10 data 2, no crash, no border.
//  4 p0 RIGHT, p1 LEFT from x=5/10 -> steps to 7/8, step3 swap into trails -> both crash,
//    game_over=1, winner_valid=0.
//  5 p0 moving UP, dir_in=DOWN -> next write at (5,3) addr 53; reversal discarded.
//  6 reset_n low mid-CLEAR at addr 40 -> busy=0, we=0 immediately; start re-clears from 0.

Source files
------------

// File: rtl/tron_arena_engine.sv
// Tron arena core: clears and optionally borders a pixel framebuffer, places riders,
// then steps them on a prescaled tick, detecting crashes through a sync-read RAM.
module tron_arena_engine #(
   parameter int NUM_PLAYERS    = 4,
   parameter int SCREEN_WIDTH   = 320,
   parameter int SCREEN_HEIGHT  = 240,
   parameter int ADDR_W         = 19,
   parameter int COLOR_W        = 3,
   parameter int CLOCKS_BY_TICK = 100000,
   parameter int STEP_TICKS     = 12
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic                           wrap_mode,
   input  logic [NUM_PLAYERS-1:0]         active_mask,
   input  logic [2*NUM_PLAYERS-1:0]       dir_in,
   output logic [ADDR_W-1:0]              ram_address,
   output logic                           ram_write_enabled,
   output logic [COLOR_W-1:0]             ram_write_data,
   input  logic [COLOR_W-1:0]             ram_read_data,
   output logic                           busy,
   output logic [NUM_PLAYERS-1:0]         alive,
   output logic                           game_over,
   output logic                           winner_valid,
   output logic [$clog2(NUM_PLAYERS)-1:0] winner_id
);

   localparam int XW       = $clog2(SCREEN_WIDTH);
   localparam int YW       = $clog2(SCREEN_HEIGHT);
   localparam int IW       = $clog2(NUM_PLAYERS);
   localparam int NPIX     = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int WAIT_CYC = CLOCKS_BY_TICK * STEP_TICKS;
   localparam int WW       = $clog2(WAIT_CYC + 1);

   localparam logic [XW-1:0] X_MAX   = XW'(SCREEN_WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX   = YW'(SCREEN_HEIGHT - 1);
   localparam logic [1:0]    D_UP    = 2'd0;
   localparam logic [1:0]    D_RIGHT = 2'd1;
   localparam logic [1:0]    D_DOWN  = 2'd2;
   localparam logic [1:0]    D_LEFT  = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_BORDER, S_PLACE, S_WAIT,
      S_STEP, S_READ, S_CHECK, S_WRITE, S_OVER
   } state_t;

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return ADDR_W'(int'(y) * SCREEN_WIDTH + int'(x));
   endfunction

   function automatic logic [COLOR_W-1:0] color_of(input logic [IW-1:0] i);
      return COLOR_W'(i) + COLOR_W'(1);
   endfunction

   // Lowest set index at or above 'from'; NUM_PLAYERS when there is none.
   function automatic int first_set(input logic [NUM_PLAYERS-1:0] m, input int from);
      int r;
      r = NUM_PLAYERS;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--)
         if (i >= from && m[i]) r = i;
      return r;
   endfunction

   function automatic int count_ones(input logic [NUM_PLAYERS-1:0] m);
      int c;
      c = 0;
      for (int i = 0; i < NUM_PLAYERS; i++) c += int'(m[i]);
      return c;
   endfunction

   function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x, input logic [1:0] d);
      logic [XW-1:0] r;
      r = x;
      if (d == D_RIGHT)     r = (x == X_MAX) ? '0 : x + XW'(1);
      else if (d == D_LEFT) r = (x == '0) ? X_MAX : x - XW'(1);
      return r;
   endfunction

   function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y, input logic [1:0] d);
      logic [YW-1:0] r;
      r = y;
      if (d == D_DOWN)    r = (y == Y_MAX) ? '0 : y + YW'(1);
      else if (d == D_UP) r = (y == '0) ? Y_MAX : y - YW'(1);
      return r;
   endfunction

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      clr_q, clr_d;
   logic [XW-1:0]          bx_q, bx_d;
   logic [YW-1:0]          by_q, by_d;
   logic [WW-1:0]          wcnt_q, wcnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   wrap_q, wrap_d;
   logic [NUM_PLAYERS-1:0] active_q, active_d;
   logic [NUM_PLAYERS-1:0] alive_q, alive_d;
   logic [NUM_PLAYERS-1:0] crash_q, crash_d;
   logic [XW-1:0]          px_q [NUM_PLAYERS];
   logic [XW-1:0]          px_d [NUM_PLAYERS];
   logic [YW-1:0]          py_q [NUM_PLAYERS];
   logic [YW-1:0]          py_d [NUM_PLAYERS];
   logic [XW-1:0]          nx_q [NUM_PLAYERS];
   logic [XW-1:0]          nx_d [NUM_PLAYERS];
   logic [YW-1:0]          ny_q [NUM_PLAYERS];
   logic [YW-1:0]          ny_d [NUM_PLAYERS];
   logic [1:0]             dir_q [NUM_PLAYERS];
   logic [1:0]             dir_d [NUM_PLAYERS];

   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   we_q, we_d;
   logic [COLOR_W-1:0]     data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   over_q, over_d;
   logic                   wv_q, wv_d;
   logic [IW-1:0]          wid_q, wid_d;

   int                     nxt;
   logic [1:0]             nd;
   logic                   go_place;
   logic                   settle;
   logic [NUM_PLAYERS-1:0] wmask;

   always_comb begin
      state_d  = state_q;
      clr_d    = clr_q;
      bx_d     = bx_q;
      by_d     = by_q;
      wcnt_d   = wcnt_q;
      idx_d    = idx_q;
      wrap_d   = wrap_q;
      active_d = active_q;
      alive_d  = alive_q;
      crash_d  = crash_q;
      px_d     = px_q;
      py_d     = py_q;
      nx_d     = nx_q;
      ny_d     = ny_q;
      dir_d    = dir_q;
      nxt      = 0;
      nd       = '0;
      go_place = 1'b0;
      settle   = 1'b0;
      wmask    = alive_q & ~crash_q;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d  = S_CLEAR;
               clr_d    = '0;
               wrap_d   = wrap_mode;
               active_d = active_mask;
               alive_d  = '0;
               crash_d  = '0;
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  px_d[i]  = XW'((i + 1) * SCREEN_WIDTH / (NUM_PLAYERS + 1));
                  py_d[i]  = YW'(SCREEN_HEIGHT / 2);
                  dir_d[i] = (i % 2 == 0) ? D_UP : D_DOWN;
               end
            end
         end
         S_CLEAR: begin
            if (clr_q == ADDR_W'(NPIX - 1)) begin
               if (wrap_q) go_place = 1'b1;
               else begin
                  state_d = S_BORDER;
                  bx_d    = '0;
                  by_d    = '0;
               end
            end else clr_d = clr_q + ADDR_W'(1);
         end
         S_BORDER: begin
            // Full top/bottom rows; interior rows only touch x=0 and x=W-1.
            if (by_q == Y_MAX && bx_q == X_MAX) go_place = 1'b1;
            else if (by_q == '0 || by_q == Y_MAX) begin
               if (bx_q == X_MAX) begin
                  bx_d = '0;
                  by_d = by_q + YW'(1);
               end else bx_d = bx_q + XW'(1);
            end else if (bx_q == '0) bx_d = X_MAX;
            else begin
               bx_d = '0;
               by_d = by_q + YW'(1);
            end
         end
         S_PLACE: begin
            nxt = first_set(active_q, int'(idx_q) + 1);
            if (nxt < NUM_PLAYERS) idx_d = IW'(nxt);
            else begin
               alive_d = active_q;
               settle  = 1'b1;
            end
         end
         S_WAIT: begin
            if (wcnt_q == WW'(WAIT_CYC - 1)) begin
               state_d = S_STEP;
               wcnt_d  = '0;
            end else wcnt_d = wcnt_q + WW'(1);
         end
         S_STEP: begin
            crash_d = '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               nd = dir_in[2*i +: 2];
               if (alive_q[i]) begin
                  if (nd != (dir_q[i] ^ 2'b10)) dir_d[i] = nd;
                  nx_d[i] = step_x(px_q[i], dir_d[i]);
                  ny_d[i] = step_y(py_q[i], dir_d[i]);
               end
            end
            // Two heads landing on one pixel take each other out.
            for (int i = 0; i < NUM_PLAYERS; i++)
               for (int j = 0; j < NUM_PLAYERS; j++)
                  if (i != j && alive_q[i] && alive_q[j] &&
                      nx_d[i] == nx_d[j] && ny_d[i] == ny_d[j])
                     crash_d[i] = 1'b1;
            idx_d   = IW'(first_set(alive_q, 0));
            state_d = S_READ;
         end
         S_READ: state_d = S_CHECK;
         S_CHECK: begin
            if (ram_read_data != '0) crash_d[idx_q] = 1'b1;
            nxt = first_set(alive_q, int'(idx_q) + 1);
            if (nxt < NUM_PLAYERS) begin
               idx_d   = IW'(nxt);
               state_d = S_READ;
            end else begin
               wmask = alive_q & ~crash_d;
               nxt   = first_set(wmask, 0);
               if (nxt < NUM_PLAYERS) begin
                  idx_d   = IW'(nxt);
                  state_d = S_WRITE;
               end else begin
                  alive_d = wmask;
                  settle  = 1'b1;
               end
            end
         end
         S_WRITE: begin
            px_d[idx_q] = nx_q[idx_q];
            py_d[idx_q] = ny_q[idx_q];
            nxt = first_set(wmask, int'(idx_q) + 1);
            if (nxt < NUM_PLAYERS) idx_d = IW'(nxt);
            else begin
               alive_d = wmask;
               settle  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (go_place) begin
         nxt = first_set(active_q, 0);
         if (nxt < NUM_PLAYERS) begin
            state_d = S_PLACE;
            idx_d   = IW'(nxt);
         end else begin
            alive_d = active_q;
            settle  = 1'b1;
         end
      end
      if (settle) begin
         wcnt_d  = '0;
         state_d = (count_ones(alive_d) >= 2) ? S_WAIT : S_OVER;
      end
   end

   // Outputs are registered from the state being entered, so the RAM port
   // always shows the access belonging to the current state.
   always_comb begin
      addr_d = '0;
      we_d   = 1'b0;
      data_d = '0;
      case (state_d)
         S_CLEAR: begin
            we_d   = 1'b1;
            addr_d = clr_d;
         end
         S_BORDER: begin
            we_d   = 1'b1;
            addr_d = pix_addr(bx_d, by_d);
            data_d = '1;
         end
         S_PLACE: begin
            we_d   = 1'b1;
            addr_d = pix_addr(px_d[idx_d], py_d[idx_d]);
            data_d = color_of(idx_d);
         end
         S_READ:  addr_d = pix_addr(nx_d[idx_d], ny_d[idx_d]);
         S_WRITE: begin
            we_d   = 1'b1;
            addr_d = pix_addr(nx_d[idx_d], ny_d[idx_d]);
            data_d = color_of(idx_d);
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
      over_d = (state_d == S_OVER);
      wv_d   = over_d && (count_ones(alive_d) == 1);
      wid_d  = wv_d ? IW'(first_set(alive_d, 0)) : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         clr_q    <= '0;
         bx_q     <= '0;
         by_q     <= '0;
         wcnt_q   <= '0;
         idx_q    <= '0;
         wrap_q   <= 1'b0;
         active_q <= '0;
         alive_q  <= '0;
         crash_q  <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            px_q[i]  <= '0;
            py_q[i]  <= '0;
            nx_q[i]  <= '0;
            ny_q[i]  <= '0;
            dir_q[i] <= '0;
         end
         addr_q   <= '0;
         we_q     <= 1'b0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         over_q   <= 1'b0;
         wv_q     <= 1'b0;
         wid_q    <= '0;
      end else begin
         state_q  <= state_d;
         clr_q    <= clr_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         wcnt_q   <= wcnt_d;
         idx_q    <= idx_d;
         wrap_q   <= wrap_d;
         active_q <= active_d;
         alive_q  <= alive_d;
         crash_q  <= crash_d;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            px_q[i]  <= px_d[i];
            py_q[i]  <= py_d[i];
            nx_q[i]  <= nx_d[i];
            ny_q[i]  <= ny_d[i];
            dir_q[i] <= dir_d[i];
         end
         addr_q   <= addr_d;
         we_q     <= we_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         over_q   <= over_d;
         wv_q     <= wv_d;
         wid_q    <= wid_d;
      end
   end

   assign ram_address       = addr_q;
   assign ram_write_enabled = we_q;
   assign ram_write_data    = data_q;
   assign busy              = busy_q;
   assign alive             = alive_q;
   assign game_over         = over_q;
   assign winner_valid      = wv_q;
   assign winner_id         = wid_q;

endmodule

// File: tb/tb_tron_arena_engine.sv
// Directed bench for tron_arena_engine on a 16x8 arena with two riders; writes are
// logged and compared against hand-derived pixel sequences.
module tb_tron_arena_engine;

   localparam int N  = 2;
   localparam int W  = 16;
   localparam int H  = 8;
   localparam int AW = 19;
   localparam int CW = 3;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic            wrap_mode = 1'b0;
   logic [N-1:0]    active_mask = 2'b11;
   logic [2*N-1:0]  dir_in = '0;
   logic [AW-1:0]   ram_address;
   logic            ram_write_enabled;
   logic [CW-1:0]   ram_write_data;
   logic [CW-1:0]   ram_read_data = '0;
   logic            busy;
   logic [N-1:0]    alive;
   logic            game_over;
   logic            winner_valid;
   logic [0:0]      winner_id;

   int n_checks = 0;
   int n_errors = 0;

   logic [CW-1:0]        mem [W*H];
   logic [AW+CW-1:0]     wr_q[$];
   logic [AW+CW-1:0]     exp_q[$];

   tron_arena_engine #(
      .NUM_PLAYERS(N), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW),
      .COLOR_W(CW), .CLOCKS_BY_TICK(2), .STEP_TICKS(2)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .wrap_mode(wrap_mode),
      .active_mask(active_mask), .dir_in(dir_in), .ram_address(ram_address),
      .ram_write_enabled(ram_write_enabled), .ram_write_data(ram_write_data),
      .ram_read_data(ram_read_data), .busy(busy), .alive(alive),
      .game_over(game_over), .winner_valid(winner_valid), .winner_id(winner_id)
   );

   // clock / reset block
   always #5 clock = ~clock;

   initial for (int i = 0; i < W*H; i++) mem[i] = '0;

   // synchronous-read framebuffer model
   always @(posedge clock) begin
      if (ram_write_enabled) mem[ram_address[6:0]] <= ram_write_data;
      ram_read_data <= mem[ram_address[6:0]];
   end

   always @(negedge clock)
      if (reset_n && ram_write_enabled) wr_q.push_back({ram_address, ram_write_data});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic exp_wr(input int a, input int d);
      exp_q.push_back({AW'(a), CW'(d)});
   endtask

   task automatic start_game(input logic wrap, input logic [N-1:0] mask, input logic [2*N-1:0] dirs);
      @(negedge clock);
      wrap_mode   = wrap;
      active_mask = mask;
      dir_in      = dirs;
      wr_q.delete();
      exp_q.delete();
      start       = 1'b1;
      @(negedge clock);
      start       = 1'b0;
   endtask

   task automatic wait_over();
      int n;
      n = 0;
      while (!game_over && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check("over_reached", game_over, 1);
   endtask

   task automatic check_setup(input logic bordered);
      int bad, a, x, y;
      logic [AW+CW-1:0] e;
      logic [W*H-1:0] seen;
      bad = 0;
      for (int i = 0; i < W*H; i++)
         if (i >= wr_q.size() || wr_q[i] != {AW'(i), CW'(0)}) bad++;
      check("clear_seq", bad, 0);
      if (bordered) begin
         bad  = 0;
         seen = '0;
         for (int i = W*H; i < W*H + 44; i++) begin
            e = (i < wr_q.size()) ? wr_q[i] : '1;
            a = int'(e[AW+CW-1:CW]);
            x = a % W;
            y = a / W;
            if (e[CW-1:0] != 3'd7 || a >= W*H || !(x == 0 || x == W-1 || y == 0 || y == H-1))
               bad++;
            else if (seen[a]) bad++;
            else seen[a] = 1'b1;
         end
         check("border_px", bad, 0);
      end
   endtask

   task automatic check_tail(input int base);
      check("wr_count", wr_q.size(), base + exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("wr%0d", base + i),
               (base + i < wr_q.size()) ? wr_q[base + i] : '1, exp_q[i]);
   endtask

   task automatic check_end(input string t, input logic [N-1:0] al, input logic wv, input logic wid);
      check({t, "_alive"}, alive, al);
      check({t, "_busy"}, busy, 0);
      check({t, "_wvalid"}, winner_valid, wv);
      check({t, "_wid"}, winner_id, wid);
   endtask

   initial begin
      bit hit;
      int n;
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_over", game_over, 0);
      check("rst_we", ram_write_enabled, 0);
      check("rst_addr", ram_address, 0);
      check("rst_alive", alive, 0);
      check("rst_wvalid", winner_valid, 0);
      reset_n = 1'b1;

      // bordered game: p0 up, p1 down into the bottom wall on step 3
      start_game(1'b0, 2'b11, {2'd2, 2'd0});
      check("t1_busy", busy, 1);
      check("t1_we", ram_write_enabled, 1);
      check("t1_addr0", ram_address, 0);
      wait_over();
      check_setup(1'b1);
      exp_wr(69, 1); exp_wr(74, 2);
      exp_wr(53, 1); exp_wr(90, 2); exp_wr(37, 1); exp_wr(106, 2); exp_wr(21, 1);
      check_tail(172);
      check_end("t1", 2'b01, 1'b1, 1'b0);

      // wrap game, no border; a start pulse mid-game must be ignored
      start_game(1'b1, 2'b11, {2'd2, 2'd0});
      repeat (50) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_over();
      check_setup(1'b0);
      exp_wr(69, 1); exp_wr(74, 2);
      exp_wr(53, 1); exp_wr(90, 2); exp_wr(37, 1); exp_wr(106, 2);
      exp_wr(21, 1); exp_wr(122, 2); exp_wr(5, 1); exp_wr(10, 2);
      exp_wr(117, 1); exp_wr(26, 2); exp_wr(101, 1); exp_wr(42, 2);
      exp_wr(85, 1); exp_wr(58, 2);
      check_tail(128);
      check_end("t3", 2'b00, 1'b0, 1'b0);

      // head-on: riders swap into each other's trails
      start_game(1'b0, 2'b11, {2'd3, 2'd1});
      wait_over();
      check_setup(1'b1);
      exp_wr(69, 1); exp_wr(74, 2);
      exp_wr(70, 1); exp_wr(73, 2); exp_wr(71, 1); exp_wr(72, 2);
      check_tail(172);
      check_end("t4", 2'b00, 1'b0, 1'b0);

      // reversal request on p0 is discarded
      start_game(1'b0, 2'b11, {2'd2, 2'd2});
      wait_over();
      exp_wr(69, 1); exp_wr(74, 2);
      exp_wr(53, 1); exp_wr(90, 2); exp_wr(37, 1); exp_wr(106, 2); exp_wr(21, 1);
      check_tail(172);
      check_end("t5", 2'b01, 1'b1, 1'b0);

      // single active rider wins straight after placement
      start_game(1'b0, 2'b10, {2'd2, 2'd2});
      wait_over();
      check_setup(1'b1);
      exp_wr(74, 2);
      check_tail(172);
      check_end("tm", 2'b10, 1'b1, 1'b1);

      // async reset mid-clear, then a fresh game
      start_game(1'b0, 2'b11, {2'd2, 2'd0});
      hit = 1'b0;
      n = 0;
      while (!hit && n < 500) begin
         @(negedge clock);
         n++;
         if (ram_write_enabled && ram_address == AW'(40)) hit = 1'b1;
      end
      check("t6_hit40", hit, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_we", ram_write_enabled, 0);
      check("t6_addr", ram_address, 0);
      check("t6_over", game_over, 0);
      @(negedge clock);
      reset_n = 1'b1;
      start_game(1'b0, 2'b11, {2'd2, 2'd0});
      wait_over();
      check_setup(1'b1);
      exp_wr(69, 1); exp_wr(74, 2);
      exp_wr(53, 1); exp_wr(90, 2); exp_wr(37, 1); exp_wr(106, 2); exp_wr(21, 1);
      check_tail(172);
      check_end("t6", 2'b01, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
